pnode_dispatcher: RTL and testbench

- Parametrised successor to the fixed 8-node input distribution network.
- Accepts the muxed Avalon-ST Ethernet stream (data, channel, sop, eop) in the 312 MHz domain and dispatches whole packets to NODES processing nodes, each through a private FIFO of DEPTH words.
- Node selection is round-robin over eligible nodes, or a channel hash, chosen by MODE.
- Adds what the fixed network lacks: packet-atomic dispatch, orphan-beat dropping, protocol-error flagging and a drop counter.

---
 rtl/pnode_dispatcher.sv | 131 +++++++++++++
 tb/tb_pnode_dispatcher.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnode_dispatcher.sv
// pnode_dispatcher: packet-atomic dispatch of a muxed Avalon-ST stream into NODES show-ahead FIFOs,
// choosing round-robin over nodes with room (MODE 0) or by channel hash (MODE 1).
module pnode_dispatcher #(
    parameter int NODES    = 8,
    parameter int DW       = 64,
    parameter int CW       = 8,
    parameter int DEPTH    = 32,
    parameter int MIN_FREE = 4,
    parameter int MODE     = 0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [DW-1:0]              st_data,
    input  logic [CW-1:0]              st_channel,
    input  logic                       st_sop,
    input  logic                       st_eop,
    input  logic                       st_valid,
    output logic                       st_ready,
    output logic [NODES*(DW+CW+2)-1:0] pnode_data,
    output logic [NODES-1:0]           pnode_valid,
    input  logic [NODES-1:0]           pnode_ready,
    output logic                       proto_err,
    output logic [15:0]                drop_count
);
    localparam int W  = DW + CW + 2;
    localparam int NW = $clog2(NODES);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_PKT} state_t;

    state_t           r_state, w_next;
    logic             r_live, r_perr;
    logic [NW-1:0]    r_cur, r_rr;
    logic [15:0]      r_drop;
    logic [NODES-1:0] w_elig, w_full, w_push, w_pop, w_rot;
    logic [NW-1:0]    w_rr_off, w_rr_tgt, w_hash, w_tgt, w_dst;
    logic [NW:0]      w_sum;
    logic             w_rr_hit, w_tgt_ok, w_ready, w_acc, w_wr, w_drop, w_perr;
    logic [W-1:0]     w_word;

    assign w_word = {st_sop, st_eop, st_channel, st_data};

    for (genvar k = 0; k < NODES; k++) begin : g_node
        logic [W-1:0] r_mem [DEPTH];
        logic [AW:0]  r_wp, r_rp, w_lvl;
        assign w_lvl          = r_wp - r_rp;
        assign w_full[k]      = w_lvl == (AW+1)'(DEPTH);
        assign w_elig[k]      = ((AW+1)'(DEPTH) - w_lvl) >= (AW+1)'(MIN_FREE);
        assign pnode_valid[k] = w_lvl != '0;
        assign pnode_data[k*W +: W] = r_mem[r_rp[AW-1:0]];
        assign w_pop[k]       = pnode_valid[k] & pnode_ready[k];
        always_ff @(posedge clock) begin
            if (w_push[k]) r_mem[r_wp[AW-1:0]] <= w_word;
        end
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push[k]) r_wp <= r_wp + 1'b1;
                if (w_pop[k])  r_rp <= r_rp + 1'b1;
            end
        end
    end

    // rotate eligibility so bit 0 is the RR pointer; the lowest set bit is the next winner
    assign w_rot = NODES'({w_elig, w_elig} >> r_rr);

    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_off = '0;
        for (int i = NODES - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rr_hit = 1'b1;
                w_rr_off = NW'(i);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr} + {1'b0, w_rr_off};
    assign w_rr_tgt = NW'((w_sum >= (NW+1)'(NODES)) ? w_sum - (NW+1)'(NODES) : w_sum);
    assign w_hash   = NW'(32'(st_channel) % NODES);
    assign w_tgt    = (MODE != 0) ? w_hash : w_rr_tgt;
    assign w_tgt_ok = (MODE != 0) ? w_elig[w_hash] : w_rr_hit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_acc)
            w_next = (r_state == S_IDLE) ? ((st_sop & ~st_eop) ? S_PKT : S_IDLE)
                                         : (st_eop ? S_IDLE : S_PKT);
    end

    // a full node may still take a beat when it is popped in the same cycle
    always_comb begin
        w_ready = r_live & ((r_state == S_IDLE) ? (~st_sop | w_tgt_ok)
                                                : (~w_full[r_cur] | pnode_ready[r_cur]));
        w_acc   = st_valid & w_ready;
        w_dst   = (r_state == S_IDLE) ? w_tgt : r_cur;
        w_wr    = w_acc & ((r_state == S_PKT) | st_sop);
        w_drop  = w_acc & (r_state == S_IDLE) & ~st_sop;
        w_perr  = w_acc & (r_state == S_PKT) & st_sop;
        w_push  = w_wr ? (NODES'(1) << w_dst) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
            r_perr <= 1'b0;
            r_cur  <= '0;
            r_rr   <= '0;
            r_drop <= '0;
        end else begin
            r_live <= 1'b1;
            r_perr <= w_perr;
            if (w_acc && r_state == S_IDLE && st_sop) begin
                r_cur <= w_tgt;
                if (MODE == 0) r_rr <= (w_tgt == NW'(NODES - 1)) ? '0 : w_tgt + 1'b1;
            end
            if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
        end
    end

    assign st_ready   = w_ready;
    assign proto_err  = r_perr;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_pnode_dispatcher.sv
// tb_pnode_dispatcher: round-robin and channel-hash instances driven side by side and checked
// every cycle against a queue-based model of the dispatch rules, plus hand-computed scenario checks.
module tb_pnode_dispatcher;
    localparam int NODES = 8, DW = 64, CW = 8, DEPTH = 32, MIN_FREE = 4, W = DW + CW + 2;

    logic clock = 1'b0, reset_n = 1'b0;
    always #5 clock = ~clock;

    logic             vld [2], sop [2], eop [2], rdy [2], perr [2];
    logic [CW-1:0]    ch  [2];
    logic [DW-1:0]    dat [2];
    logic [NODES-1:0] pr  [2], pv [2];
    logic [NODES*W-1:0] pd [2];
    logic [15:0]      dc  [2];

    pnode_dispatcher #(.NODES(NODES), .DW(DW), .CW(CW), .DEPTH(DEPTH), .MIN_FREE(MIN_FREE), .MODE(0)) u0 (
        .clock(clock), .reset_n(reset_n), .st_data(dat[0]), .st_channel(ch[0]), .st_sop(sop[0]),
        .st_eop(eop[0]), .st_valid(vld[0]), .st_ready(rdy[0]), .pnode_data(pd[0]), .pnode_valid(pv[0]),
        .pnode_ready(pr[0]), .proto_err(perr[0]), .drop_count(dc[0]));

    pnode_dispatcher #(.NODES(NODES), .DW(DW), .CW(CW), .DEPTH(DEPTH), .MIN_FREE(MIN_FREE), .MODE(1)) u1 (
        .clock(clock), .reset_n(reset_n), .st_data(dat[1]), .st_channel(ch[1]), .st_sop(sop[1]),
        .st_eop(eop[1]), .st_valid(vld[1]), .st_ready(rdy[1]), .pnode_data(pd[1]), .pnode_valid(pv[1]),
        .pnode_ready(pr[1]), .proto_err(perr[1]), .drop_count(dc[1]));

    int n_run = 0, n_fail = 0;
    logic [W-1:0] mq [2][NODES][$];
    int  mlog [2][$];
    int  mrr [2], mcur [2], mdc [2];
    bit  min_pkt [2], mlive [2], mperr [2];
    int  acc_cnt = 0, rx0 = 0, perr_cnt = 0;
    bit  rx_sop, rx_eop, rdone;

    task automatic chk(input int u, input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        n_run++;
        if (a !== e) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL u%0d %s: got %0h, expected %0h", u, nm, a, e);
        end
    endtask

    always @(negedge clock) begin
        int tgt, nd;
        bit er, v;
        logic [W-1:0] word;
        if (reset_n && pv[0][0] && pr[0][0]) begin
            if (rx0 == 0) rx_sop = pd[0][W-1];
            rx_eop = pd[0][W-2];
            rx0++;
        end
        if (perr[0]) perr_cnt++;
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                for (int k = 0; k < NODES; k++) mq[u][k].delete();
                mrr[u] = 0; mcur[u] = 0; mdc[u] = 0;
                min_pkt[u] = 0; mlive[u] = 0; mperr[u] = 0;
            end
            tgt = -1;
            if (!min_pkt[u]) begin
                if (u == 0) begin
                    for (int j = 0; j < NODES; j++) begin
                        nd = (mrr[u] + j) % NODES;
                        if (tgt < 0 && DEPTH - mq[u][nd].size() >= MIN_FREE) tgt = nd;
                    end
                end else begin
                    nd = int'(ch[u]) % NODES;
                    if (DEPTH - mq[u][nd].size() >= MIN_FREE) tgt = nd;
                end
                er = mlive[u] && (!sop[u] || tgt >= 0);
            end else
                er = mlive[u] && (mq[u][mcur[u]].size() < DEPTH || pr[u][mcur[u]]);
            chk(u, "st_ready", W'(rdy[u]), W'(er));
            chk(u, "proto_err", W'(perr[u]), W'(mperr[u]));
            chk(u, "drop_count", W'(dc[u]), W'(mdc[u]));
            for (int k = 0; k < NODES; k++) begin
                v = mq[u][k].size() != 0;
                chk(u, $sformatf("pnode_valid[%0d]", k), W'(pv[u][k]), W'(v));
                if (v) chk(u, $sformatf("pnode_data[%0d]", k), pd[u][k*W +: W], mq[u][k][0]);
            end
            if (reset_n) begin
                mperr[u] = 0;
                for (int k = 0; k < NODES; k++)
                    if (mq[u][k].size() != 0 && pr[u][k]) void'(mq[u][k].pop_front());
                if (vld[u] && er) begin
                    word = {sop[u], eop[u], ch[u], dat[u]};
                    if (!min_pkt[u]) begin
                        if (sop[u]) begin
                            mq[u][tgt].push_back(word);
                            mcur[u] = tgt;
                            mlog[u].push_back(tgt);
                            if (u == 0) mrr[u] = (tgt + 1) % NODES;
                            min_pkt[u] = !eop[u];
                        end else if (mdc[u] < 65535) mdc[u]++;
                    end else begin
                        mq[u][mcur[u]].push_back(word);
                        if (sop[u]) mperr[u] = 1;
                        if (eop[u]) min_pkt[u] = 0;
                    end
                end
                mlive[u] = 1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic beat(input int u, input bit s, input bit e, input int c);
        int t;
        bit a;
        vld[u] = 1'b1; sop[u] = s; eop[u] = e; ch[u] = CW'(c); dat[u] = {$urandom, $urandom};
        t = 0; a = 0;
        while (!a && t < 400) begin
            @(negedge clock);
            a = rdy[u];
            @(posedge clock);
            #1;
            t++;
        end
        vld[u] = 1'b0;
        if (!a) begin
            n_run++; n_fail++;
            $display("FAIL u%0d beat_timeout: got no st_ready, expected acceptance within 400 cycles", u);
        end else acc_cnt++;
    endtask

    task automatic pkt(input int u, input int len, input int c);
        for (int i = 0; i < len; i++) beat(u, i == 0, i == len - 1, c);
    endtask

    task automatic rnd(input int u);
        int c, len;
        for (int n = 0; n < 150; n++) begin
            c = int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) beat(u, 1'b0, 1'($urandom_range(0, 1)), c);
            else begin
                len = int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) beat(u, (i == 0) || ($urandom_range(0, 19) == 0), i == len - 1, c);
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        int n;
        for (int u = 0; u < 2; u++) begin
            vld[u] = 0; sop[u] = 0; eop[u] = 0; ch[u] = '0; dat[u] = '0; pr[u] = '1;
        end
        idle(3);
        chk(0, "reset_valid", W'(pv[0]), '0);
        chk(0, "reset_ready", W'(rdy[0]), '0);
        chk(1, "reset_drop", W'(dc[1]), '0);
        reset_n = 1'b1;
        @(negedge clock);
        chk(0, "ready_after_release", W'(rdy[0]), '0);
        idle(1);
        // single-beat packets walk the nodes in order
        for (int i = 0; i < 10; i++) pkt(0, 1, i);
        idle(2);
        for (int i = 0; i < 10; i++) chk(0, "rr_order", W'(mlog[0][i]), W'(i % 8));
        chk(0, "rr_drop", W'(dc[0]), '0);
        // node 1 left with 3 free words is skipped
        for (int i = 0; i < 7; i++) pkt(0, 1, 0);
        pr[0][1] = 1'b0;
        pkt(0, 29, 0);
        for (int i = 0; i < 7; i++) pkt(0, 1, 0);
        for (int i = 0; i < 3; i++) pkt(0, 1, 0);
        n = mlog[0].size();
        chk(0, "long_to_node1", W'(mlog[0][17]), W'(1));
        chk(0, "skip_a", W'(mlog[0][n-3]), W'(2));
        chk(0, "skip_b", W'(mlog[0][n-2]), W'(3));
        chk(0, "skip_c", W'(mlog[0][n-1]), W'(4));
        chk(0, "node1_holding", W'(pv[0][1]), W'(1));
        pr[0][1] = 1'b1;
        idle(40);
        // 40-beat packet into a stalled node 0
        for (int i = 0; i < 3; i++) pkt(0, 1, 0);
        idle(2);
        pr[0][0] = 1'b0; acc_cnt = 0; rx0 = 0;
        fork
            pkt(0, 40, 0);
            begin
                idle(60);
                chk(0, "stall_after_32", W'(acc_cnt), W'(32));
                chk(0, "stall_ready", W'(rdy[0]), '0);
                pr[0][0] = 1'b1;
            end
        join
        idle(50);
        chk(0, "rx_count", W'(rx0), W'(40));
        chk(0, "rx_first_sop", W'(rx_sop), W'(1));
        chk(0, "rx_last_eop", W'(rx_eop), W'(1));
        // orphans and a nested sop
        beat(0, 0, 0, 0);
        beat(0, 0, 1, 0);
        chk(0, "orphan_drops", W'(dc[0]), W'(2));
        perr_cnt = 0; n = mlog[0].size();
        beat(0, 1, 0, 0);
        beat(0, 1, 0, 0);
        beat(0, 0, 1, 0);
        idle(2);
        chk(0, "proto_err_pulses", W'(perr_cnt), W'(1));
        chk(0, "no_reselect", W'(mlog[0].size()), W'(n + 1));
        // reset in the middle of a packet
        beat(0, 1, 0, 0);
        beat(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        chk(0, "rst_valid", W'(pv[0]), '0);
        chk(0, "rst_ready", W'(rdy[0]), '0);
        idle(2);
        reset_n = 1'b1;
        @(negedge clock);
        chk(0, "rst_ready_gap", W'(rdy[0]), '0);
        idle(1);
        beat(0, 0, 0, 0);
        beat(0, 0, 1, 0);
        chk(0, "rst_drops", W'(dc[0]), W'(2));
        pkt(0, 1, 0);
        chk(0, "rst_first_node", W'(mlog[0][mlog[0].size()-1]), '0);
        // channel hash with node 3 backpressured
        pr[1][3] = 1'b0;
        pkt(1, 30, 3);
        fork
            begin pkt(1, 1, 11); pkt(1, 1, 5); end
            begin
                idle(20);
                chk(1, "hash_blocked", W'(rdy[1]), '0);
                chk(1, "hash_in_order", W'(pv[1][5]), '0);
                pr[1][3] = 1'b1;
            end
        join
        idle(40);
        chk(1, "hash_count", W'(mlog[1].size()), W'(3));
        chk(1, "hash_a", W'(mlog[1][0]), W'(3));
        chk(1, "hash_b", W'(mlog[1][1]), W'(3));
        chk(1, "hash_c", W'(mlog[1][2]), W'(5));
        // random traffic with random node backpressure
        rdone = 0;
        fork
            begin
                fork rnd(0); rnd(1); join
                rdone = 1;
            end
            while (!rdone) begin
                idle(1);
                pr[0] = NODES'($urandom | $urandom);
                pr[1] = NODES'($urandom | $urandom);
            end
        join
        pr[0] = '1; pr[1] = '1;
        idle(60);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_run++; n_fail++;
        $display("FAIL watchdog: got no end of stimulus, expected it within 50000 cycles");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
